fifo_rd_packer: RTL and testbench

//  Read-side consumer of the async FIFO; runs in the FIFO read clock domain.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_out_reg_slice.sv | 56 +++++
 rtl/fifo_rd_packer.sv | 134 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side packer.
// FSM encoding, default widths and the lane-count width helper.
package fifo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK_RATIO = 4;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_out_reg_slice.sv
// One-entry valid/ready register for the packed word and its keep mask.
// Holds data stable while stalled; accepts a new word as the old one leaves.
module fifo_out_reg_slice
  import fifo_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH * DEF_PACK_RATIO,
  parameter int K = DEF_PACK_RATIO
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [K-1:0] in_keep,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [K-1:0] out_keep
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic [K-1:0] keep_q, keep_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
      keep_d  = in_keep;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_keep  = keep_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries and packs PACK_RATIO of them into one valid/ready word.
// Optional idle auto-flush: define FIFO_RD_PACKER_TIMEOUT_EN.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int PACK_RATIO     = DEF_PACK_RATIO,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst_n,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep,
  output logic                             busy
);

  localparam int CW = cnt_w(PACK_RATIO);
  localparam int OW = DATA_WIDTH * PACK_RATIO;
  localparam logic [CW-1:0] FULL = CW'(PACK_RATIO);

  if (PACK_RATIO < 2) begin : g_bad_ratio
    $error("PACK_RATIO must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d, cnt_pop;
  logic [OW-1:0]   lanes_q, lanes_d, lanes_pop;
  logic [PACK_RATIO-1:0] keep_w;
  logic            pop, flush_req, xfer_req, xfer;
  logic            slot_ready;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] TO_MAX = IW'(TIMEOUT_CYCLES);

  logic [IW-1:0] idle_q, idle_d;
  logic          to_flush;

  assign to_flush  = (count_q != '0) && (idle_q == TO_MAX);
  assign flush_req = flush || to_flush;

  always_comb begin
    idle_d = idle_q;
    if (pop || count_q == '0) begin
      idle_d = '0;
    end else if (idle_q != TO_MAX) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) idle_q <= '0;
    else           idle_q <= idle_d;
  end
`else
  assign flush_req = flush;
`endif

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) state_q <= FILL;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (xfer_req && !xfer) state_d = HOLD;
      HOLD: if (xfer) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // A flush may coincide with a pop; the popped entry rides along.
  always_comb begin
    pop = rd_rst_n && (state_q == FILL)
       && !fifo_empty && (count_q < FULL);
    xfer_req = (state_q == HOLD) || (count_q == FULL)
            || (flush_req && cnt_pop != '0);
    xfer = xfer_req && slot_ready;
  end

  always_comb begin
    cnt_pop   = count_q + CW'(pop);
    lanes_pop = lanes_q;
    keep_w    = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (pop && count_q == CW'(i)) begin
        lanes_pop[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      end
      keep_w[i] = (CW'(i) < cnt_pop);
    end
    count_d = xfer ? '0 : cnt_pop;
    lanes_d = xfer ? '0 : lanes_pop;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      count_q <= '0;
      lanes_q <= '0;
    end else begin
      count_q <= count_d;
      lanes_q <= lanes_d;
    end
  end

  fifo_out_reg_slice #(
    .W (OW),
    .K (PACK_RATIO)
  ) u_slice (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .in_valid  (xfer),
    .in_ready  (slot_ready),
    .in_data   (lanes_pop),
    .in_keep   (keep_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep)
  );

  assign fifo_rd_en = pop;
  assign busy = (count_q != '0) || (state_q == HOLD) || out_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a queue-backed FWFT FIFO model.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rd_rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int npops  = 0;

  logic [7:0]  fq[$];
  logic [31:0] gd[$];
  logic [3:0]  gk[$];

  always #5 clk = ~clk;

  fifo_rd_packer dut (
    .rd_clk     (clk),
    .rd_rst_n   (rd_rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .busy       (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fq[0];
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    refresh();
  endtask

  // Sample handshakes just before the edge, apply their effect after it.
  task automatic tick();
    logic p;
    #1;
    p = fifo_rd_en;
    if (out_valid && out_ready) begin
      gd.push_back(out_data);
      gk.push_back(out_keep);
    end
    @(posedge clk);
    #1;
    if (p && fq.size() > 0) begin
      void'(fq.pop_front());
      npops++;
    end
    refresh();
  endtask

  initial begin
    int seen;
    int p0;
    // Reset
    rd_rst_n   = 1'b0;
    fifo_empty = 1'b0;
    fifo_data  = 8'h11;
    flush      = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_keep", out_keep, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    refresh();
    rd_rst_n  = 1'b1;
    out_ready = 1'b1;

    // Pack four entries
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(); tick();
    chk("pack_busy", busy, 1);
    tick(); tick();
    chk("pack_pops", npops, 4);
    chk("pack_lat", out_valid, 0);
    tick();
    chk("pack_valid", out_valid, 1);
    chk("pack_data", out_data, 32'h44332211);
    chk("pack_keep", out_keep, 4'hF);
    tick();
    chk("pack_acc", gd.size(), 1);
    chk("pack_idle", busy, 0);

    // Backpressure
    gd.delete(); gk.delete();
    out_ready = 1'b0;
    p0 = npops;
    push(8'h11); push(8'h22); push(8'h33);
    push(8'h44); push(8'h55); push(8'h66);
    push(8'h77); push(8'h88); push(8'h99);
    repeat (15) tick();
    chk("bp_pops", npops - p0, 8);
    chk("bp_left", fq.size(), 1);
    chk("bp_rd_en", fifo_rd_en, 0);
    chk("bp_data", out_data, 32'h44332211);
    chk("bp_busy", busy, 1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("bp_cnt", gd.size(), 2);
    chk("bp_w0", gd[0], 32'h44332211);
    chk("bp_w1", gd[1], 32'h88776655);
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    chk("bp_w2", gd[2], 32'h00000099);
    chk("bp_k2", gk[2], 4'b0001);

    // Flush of a partial word
    gd.delete(); gk.delete();
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (3) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_data", out_data, 32'h00CCBBAA);
    chk("fl_keep", out_keep, 4'b0111);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick();
    chk("fl_empty_v", out_valid, 0);
    chk("fl_empty_n", gd.size(), 1);
    chk("fl_empty_b", busy, 0);

    // Flush coinciding with a pop, then flush while blocked
    gd.delete(); gk.delete();
    out_ready = 1'b0;
    push(8'hDD);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flp_data", out_data, 32'h000000DD);
    chk("flp_keep", out_keep, 4'b0001);
    push(8'hEE); push(8'hFF);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    push(8'h77);
    #1;
    chk("hold_rd_en", fifo_rd_en, 0);
    chk("hold_busy", busy, 1);
    out_ready = 1'b1;
    tick(); tick();
    chk("hold_w0", gd[0], 32'h000000DD);
    chk("hold_w1", gd[1], 32'h0000FFEE);
    chk("hold_k1", gk[1], 4'b0011);
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    chk("hold_w2", gd[2], 32'h00000077);

    // Mid-word reset
    gd.delete(); gk.delete();
    push(8'h01); push(8'h02);
    tick(); tick();
    rd_rst_n = 1'b0;
    tick(); tick();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    rd_rst_n = 1'b1;
    push(8'h03); push(8'h04); push(8'h05); push(8'h06);
    repeat (7) tick();
    chk("mrst_n", gd.size(), 1);
    chk("mrst_data", gd[0], 32'h06050403);
    chk("mrst_keep", gk[0], 4'hF);

    // Idle timeout
    gd.delete(); gk.delete();
    out_ready = 1'b0;
    push(8'h5A);
    tick();
    seen = 0;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    for (int i = 0; i < 40 && seen == 0; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("to_seen", seen, 1);
    chk("to_data", out_data, 32'h0000005A);
    chk("to_keep", out_keep, 4'b0001);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("to_none", seen, 0);
    chk("to_busy", busy, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
